// File: rtl/main_memory.sv
// ============================================================================
// Module      : main_memory (with memory_pkg and interface_pkg)
// Description : Fixed-latency word memory with byte-strobed writes for a cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package memory_pkg;
    localparam int ADDRESS_WIDTH    = 32;
    localparam int MEMORY_BUS_WIDTH = 32;
    localparam int ENTRIES          = 1024;
    localparam int DELAY            = 4;
endpackage

package interface_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] address;
        logic [31:0] data;
        logic [3:0]  strobe;
        logic        wen;
    } Memory_Request;

    typedef struct packed {
        logic [31:0] data;
        logic        valid;
    } Memory_Response;
endpackage

module main_memory #(
    parameter int ADDRESS_WIDTH    = memory_pkg::ADDRESS_WIDTH,
    parameter int MEMORY_BUS_WIDTH = memory_pkg::MEMORY_BUS_WIDTH,
    parameter int ENTRIES          = memory_pkg::ENTRIES,
    parameter int DELAY            = memory_pkg::DELAY
) (
    input  logic                          clk,
    input  logic                          rst,
    input  interface_pkg::Memory_Request  memory_request,
    output interface_pkg::Memory_Response memory_response
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = $clog2(DELAY + 1);
    localparam int BYTES = MEMORY_BUS_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [CNT_W-1:0]              r_cnt;
    logic [IDX_W-1:0]              r_idx;
    logic [MEMORY_BUS_WIDTH-1:0]   r_data;
    logic [BYTES-1:0]              r_strobe;
    logic                          r_wen;
    logic [MEMORY_BUS_WIDTH-1:0]   r_rdata;
    logic [MEMORY_BUS_WIDTH-1:0]   r_mem [ENTRIES] = '{default: '0};

    logic                          w_accept;
    logic                          w_enter_resp;
    logic [IDX_W-1:0]              w_idx;
    logic [MEMORY_BUS_WIDTH-1:0]   w_data;
    logic [BYTES-1:0]              w_strobe;
    logic                          w_wen;
    logic [MEMORY_BUS_WIDTH-1:0]   w_merged;
    logic                          w_unused_addr;

    // Address bits outside the word index carry no meaning (alignment/aliasing).
    assign w_unused_addr = ^{memory_request.address[ADDRESS_WIDTH-1:IDX_W+2],
                             memory_request.address[1:0]};

    assign w_accept = (r_state == IDLE) && memory_request.valid;

    // With DELAY=1 the commit happens on the accepting edge, before the latch
    // holds anything, so the live request fields are used on that edge.
    assign w_idx    = w_accept ? memory_request.address[IDX_W+1:2]        : r_idx;
    assign w_data   = w_accept ? memory_request.data[MEMORY_BUS_WIDTH-1:0] : r_data;
    assign w_strobe = w_accept ? memory_request.strobe[BYTES-1:0]          : r_strobe;
    assign w_wen    = w_accept ? memory_request.wen                        : r_wen;

    always_comb begin
        w_merged = r_mem[w_idx];
        for (int i = 0; i < BYTES; i++) begin
            if (w_wen && w_strobe[i]) begin
                w_merged[8*i +: 8] = w_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (memory_request.valid) begin
                    w_next = (DELAY == 1) ? RESPOND : BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next = RESPOND;
                end
            end
            RESPOND: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_enter_resp = (w_next == RESPOND) && (r_state != RESPOND);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_data   <= '0;
            r_strobe <= '0;
            r_wen    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_accept) begin
                r_idx    <= memory_request.address[IDX_W+1:2];
                r_data   <= memory_request.data[MEMORY_BUS_WIDTH-1:0];
                r_strobe <= memory_request.strobe[BYTES-1:0];
                r_wen    <= memory_request.wen;
                r_cnt    <= CNT_W'(DELAY - 1);
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_enter_resp) begin
                r_rdata <= w_merged;
            end
        end
    end

    // Storage has no reset: contents survive rst, and an aborted write never commits.
    always_ff @(posedge clk) begin
        if (!rst && w_enter_resp && w_wen) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_comb begin
        memory_response       = '0;
        memory_response.valid = (r_state == RESPOND);
        if (r_state == RESPOND) begin
            memory_response.data = r_rdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_main_memory.sv
// ============================================================================
// Module      : tb_main_memory
// Description : Directed scoreboard bench for main_memory (DELAY=4 and DELAY=1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_main_memory;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    interface_pkg::Memory_Request  req0, req1;
    interface_pkg::Memory_Response rsp0, rsp1;

    logic [31:0] q_data [2][$];
    int          q_cyc  [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    main_memory #(.DELAY(4)) dut (
        .clk(clk), .rst(rst), .memory_request(req0), .memory_response(rsp0)
    );

    main_memory #(.DELAY(1)) dut1 (
        .clk(clk), .rst(rst), .memory_request(req1), .memory_response(rsp1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic monitor_port(input int p, input interface_pkg::Memory_Response r);
        logic [31:0] d;
        int          c;
        if (r.valid) begin
            check($sformatf("rsp%0d_expected", p), 32'(q_data[p].size() != 0), 32'd1);
            if (q_data[p].size() != 0) begin
                d = q_data[p].pop_front();
                c = q_cyc[p].pop_front();
                check($sformatf("rsp%0d_data", p), r.data, d);
                check($sformatf("rsp%0d_cycle", p), 32'(cyc), 32'(c));
            end
        end else begin
            check($sformatf("rsp%0d_idle_data", p), r.data, 32'h0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            monitor_port(0, rsp0);
            monitor_port(1, rsp1);
        end
    end

    // Issue one request, queue its expected data/cycle, wait for the response.
    task automatic do_req(input int p, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic wen, input logic [31:0] exp);
        interface_pkg::Memory_Request r;
        int dly;
        bit got;
        r   = '{valid: 1'b1, address: addr, data: data, strobe: strb, wen: wen};
        dly = (p == 1) ? 1 : 4;
        got = 1'b0;
        @(negedge clk);
        if (p == 1) req1 = r; else req0 = r;
        @(posedge clk);
        #1;
        q_data[p].push_back(exp);
        q_cyc[p].push_back(cyc + dly - 1);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((p == 1) ? rsp1.valid : rsp0.valid) begin
                got = 1'b1;
                break;
            end
        end
        if (p == 1) req1.valid = 1'b0; else req0.valid = 1'b0;
        check($sformatf("rsp%0d_arrived_%h", p, addr), 32'(got), 32'd1);
    endtask

    initial begin
        int n;
        req0 = '0;
        req1 = '0;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(rsp0.valid), 32'd0);
        check("reset_data", rsp0.data, 32'h0);
        check("reset_valid_d1", 32'(rsp1.valid), 32'd0);
        rst = 1'b0;

        // Full write then read-back
        do_req(0, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 1'b1, 32'hDEADBEEF);
        do_req(0, 32'h0000_0010, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF);

        // Byte-strobed merge
        do_req(0, 32'h0000_0020, 32'h11223344, 4'hF,    1'b1, 32'h11223344);
        do_req(0, 32'h0000_0020, 32'hAABBCCDD, 4'b0101, 1'b1, 32'h11BB33DD);
        do_req(0, 32'h0000_0020, 32'h0,        4'h0,    1'b0, 32'h11BB33DD);

        // Aliasing and ignored low address bits
        do_req(0, 32'h0000_0004, 32'hCAFEF00D, 4'hF, 1'b1, 32'hCAFEF00D);
        do_req(0, 32'h0000_1004, 32'h0,        4'h0, 1'b0, 32'hCAFEF00D);
        do_req(0, 32'h0000_0007, 32'h0,        4'h0, 1'b0, 32'hCAFEF00D);

        // Zero-strobe write leaves the word intact but still responds
        do_req(0, 32'h0000_0010, 32'h0BAD0BAD, 4'h0, 1'b1, 32'hDEADBEEF);

        // Reset two cycles after accepting a write aborts it
        @(negedge clk);
        req0 = '{valid: 1'b1, address: 32'h40, data: 32'h12345678, strobe: 4'hF, wen: 1'b1};
        @(posedge clk);
        @(negedge clk);
        req0.valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", 32'(rsp0.valid), 32'd0);
        check("abort_data", rsp0.data, 32'h0);
        repeat (8) @(negedge clk);
        do_req(0, 32'h0000_0040, 32'h0, 4'h0, 1'b0, 32'h00000000);

        // Valid held high, address changed while busy
        @(negedge clk);
        req0 = '{valid: 1'b1, address: 32'h20, data: 32'h0, strobe: 4'h0, wen: 1'b0};
        @(posedge clk);
        #1;
        q_data[0].push_back(32'h11BB33DD);
        q_cyc[0].push_back(cyc + 3);
        q_data[0].push_back(32'hCAFEF00D);
        q_cyc[0].push_back(cyc + 3 + 5);
        @(negedge clk);
        @(negedge clk);
        req0.address = 32'h0000_0004;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp0.valid) n++;
            if (n == 2) begin
                req0.valid = 1'b0;
                break;
            end
        end
        check("held_valid_responses", 32'(n), 32'd2);

        // Single-cycle latency instance
        do_req(1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 1'b1, 32'hDEADBEEF);
        do_req(1, 32'h0000_0010, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF);

        repeat (6) @(negedge clk);
        check("queue0_drained", 32'(q_data[0].size()), 32'd0);
        check("queue1_drained", 32'(q_data[1].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
